// File: rtl/preamble_inserter.sv
// preamble_inserter: transmit-side OFDM framer.
// Emits the short training sequence (STS_REPS x 16 samples), then the long
// training guard (tail of the LTS table) and two full 64-sample LTS symbols,
// then forwards payload samples until the burst length is exhausted.
// Samples are signed Q2.10 of width `FIXED_POINT_WIDTH (13 by default).
// The constant tables below carry the preamble_rom.vh contents.
// Optional feature macro: PREAMBLE_WINDOW_EN (soft edges on the STS start and
// on the STS-to-LTS boundary; sample count is unchanged).

`ifndef FIXED_POINT_WIDTH
`define FIXED_POINT_WIDTH 13
`endif

module preamble_inserter #(
  parameter int STS_REPS   = 10,
  parameter int LTS_GI_LEN = 32,
  parameter int LEN_W      = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LEN_W-1:0]              payload_len,
  input  logic [`FIXED_POINT_WIDTH-1:0] din_real,
  input  logic [`FIXED_POINT_WIDTH-1:0] din_imag,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [`FIXED_POINT_WIDTH-1:0] out_real,
  output logic [`FIXED_POINT_WIDTH-1:0] out_imag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          preamble_done,
  output logic                          burst_done
);

  localparam int W = `FIXED_POINT_WIDTH;

  // Index bookkeeping for the sample counter and the guard-interval offset.
  localparam logic [8:0] STS_LAST = 9'(16 * STS_REPS - 1);
  localparam logic [8:0] GI_LAST  = 9'(LTS_GI_LEN - 1);
  localparam logic [8:0] LTS_LAST = 9'd63;
  localparam logic [5:0] GI_BASE  = 6'((64 - LTS_GI_LEN) % 64);

  typedef enum logic [2:0] {
    IDLE,
    STS,
    LTS_GI,
    LTS_A,
    LTS_B,
    PAYLOAD,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic [W-1:0]     outReal_q, outReal_d;
  logic [W-1:0]     outImag_q, outImag_d;
  logic             outValid_q, outValid_d;
  logic             lastLts_q, lastLts_d;
  logic             lastBurst_q, lastBurst_d;

  logic             advance;
  logic             accept;
  logic [5:0]       ltsIdx;
  logic [2*W-1:0]   stsWord;
  logic [2*W-1:0]   ltsWord;
  logic signed [W-1:0] stsRe, stsIm, ltsRe, ltsIm;
  logic signed [W-1:0] stsSampleRe, stsSampleIm, giSampleRe, giSampleIm;

  // Packs one complex table entry as {real, imag}.
  function automatic logic [2*W-1:0] cplx(input int re, input int im);
    cplx = {W'(re), W'(im)};
  endfunction

  // Short training sequence, one 16-sample period.
  function automatic logic [2*W-1:0] stsRom(input logic [3:0] idx);
    case (idx)
      4'd0:    stsRom = cplx(  47,   47);
      4'd1:    stsRom = cplx(-135,    2);
      4'd2:    stsRom = cplx( -13,  -81);
      4'd3:    stsRom = cplx( 146,  -13);
      4'd4:    stsRom = cplx(  94,    0);
      4'd5:    stsRom = cplx( 146,  -13);
      4'd6:    stsRom = cplx( -13,  -81);
      4'd7:    stsRom = cplx(-135,    2);
      4'd8:    stsRom = cplx(  47,   47);
      4'd9:    stsRom = cplx(   2, -135);
      4'd10:   stsRom = cplx( -81,  -13);
      4'd11:   stsRom = cplx( -13,  146);
      4'd12:   stsRom = cplx(   0,   94);
      4'd13:   stsRom = cplx( -13,  146);
      4'd14:   stsRom = cplx( -81,  -13);
      default: stsRom = cplx(   2, -135);
    endcase
  endfunction

  // Long training symbol, 64 samples.
  function automatic logic [2*W-1:0] ltsRom(input logic [5:0] idx);
    case (idx)
      6'd0:    ltsRom = cplx( 160,    0);
      6'd1:    ltsRom = cplx(  -5, -123);
      6'd2:    ltsRom = cplx(  41, -114);
      6'd3:    ltsRom = cplx(  99,   85);
      6'd4:    ltsRom = cplx(  22,   29);
      6'd5:    ltsRom = cplx(  61,  -90);
      6'd6:    ltsRom = cplx(-118,  -56);
      6'd7:    ltsRom = cplx( -39, -109);
      6'd8:    ltsRom = cplx( 100,  -27);
      6'd9:    ltsRom = cplx(  54,    4);
      6'd10:   ltsRom = cplx(   1, -118);
      6'd11:   ltsRom = cplx(-140,  -48);
      6'd12:   ltsRom = cplx(  25,  -60);
      6'd13:   ltsRom = cplx(  60,  -15);
      6'd14:   ltsRom = cplx( -23,  165);
      6'd15:   ltsRom = cplx( 122,   -4);
      6'd16:   ltsRom = cplx(  63,  -63);
      6'd17:   ltsRom = cplx(  38,  100);
      6'd18:   ltsRom = cplx( -58,   40);
      6'd19:   ltsRom = cplx(-134,   67);
      6'd20:   ltsRom = cplx(  84,   94);
      6'd21:   ltsRom = cplx(  72,   14);
      6'd22:   ltsRom = cplx( -61,   83);
      6'd23:   ltsRom = cplx( -57,  -23);
      6'd24:   ltsRom = cplx( -36, -155);
      6'd25:   ltsRom = cplx(-125,  -17);
      6'd26:   ltsRom = cplx(-130,  -22);
      6'd27:   ltsRom = cplx(  77,  -76);
      6'd28:   ltsRom = cplx(  -3,   55);
      6'd29:   ltsRom = cplx( -94,  118);
      6'd30:   ltsRom = cplx(  94,  109);
      6'd31:   ltsRom = cplx(  12,  100);
      6'd32:   ltsRom = cplx(-160,    0);
      6'd33:   ltsRom = cplx(  12, -100);
      6'd34:   ltsRom = cplx(  94, -109);
      6'd35:   ltsRom = cplx( -94, -118);
      6'd36:   ltsRom = cplx(  -3,  -55);
      6'd37:   ltsRom = cplx(  77,   76);
      6'd38:   ltsRom = cplx(-130,   22);
      6'd39:   ltsRom = cplx(-125,   17);
      6'd40:   ltsRom = cplx( -36,  155);
      6'd41:   ltsRom = cplx( -57,   23);
      6'd42:   ltsRom = cplx( -61,  -83);
      6'd43:   ltsRom = cplx(  72,  -14);
      6'd44:   ltsRom = cplx(  84,  -94);
      6'd45:   ltsRom = cplx(-134,  -67);
      6'd46:   ltsRom = cplx( -58,  -40);
      6'd47:   ltsRom = cplx(  38, -100);
      6'd48:   ltsRom = cplx(  63,   63);
      6'd49:   ltsRom = cplx( 122,    4);
      6'd50:   ltsRom = cplx( -23, -165);
      6'd51:   ltsRom = cplx(  60,   15);
      6'd52:   ltsRom = cplx(  25,   60);
      6'd53:   ltsRom = cplx(-140,   48);
      6'd54:   ltsRom = cplx(   1,  118);
      6'd55:   ltsRom = cplx(  54,   -4);
      6'd56:   ltsRom = cplx( 100,   27);
      6'd57:   ltsRom = cplx( -39,  109);
      6'd58:   ltsRom = cplx(-118,   56);
      6'd59:   ltsRom = cplx(  61,   90);
      6'd60:   ltsRom = cplx(  22,  -29);
      6'd61:   ltsRom = cplx(  99,  -85);
      6'd62:   ltsRom = cplx(  41,  114);
      default: ltsRom = cplx(  -5,  123);
    endcase
  endfunction

  // The output register may load when it is empty or its sample is taken.
  assign advance = !outValid_q || out_ready;
  assign accept  = outValid_q && out_ready;

  // The guard interval reads the tail of the LTS table; the symbols read it from 0.
  assign ltsIdx  = (state_q == LTS_GI) ? (cnt_q[5:0] + GI_BASE) : cnt_q[5:0];
  assign stsWord = stsRom(cnt_q[3:0]);
  assign ltsWord = ltsRom(ltsIdx);
  assign stsRe   = stsWord[2*W-1:W];
  assign stsIm   = stsWord[W-1:0];
  assign ltsRe   = ltsWord[2*W-1:W];
  assign ltsIm   = ltsWord[W-1:0];

`ifdef PREAMBLE_WINDOW_EN
  logic [2*W-1:0]      stsLastWord, giFirstWord;
  logic signed [W-1:0] aRe, aIm, bRe, bIm;
  logic signed [W:0]   sumRe, sumIm, halfRe, halfIm;

  // The boundary sample blends the final STS sample with the first guard sample.
  assign stsLastWord = stsRom(4'hF);
  assign giFirstWord = ltsRom(GI_BASE);
  assign aRe    = stsLastWord[2*W-1:W];
  assign aIm    = stsLastWord[W-1:0];
  assign bRe    = giFirstWord[2*W-1:W];
  assign bIm    = giFirstWord[W-1:0];
  assign sumRe  = {aRe[W-1], aRe} + {bRe[W-1], bRe} + {{W{1'b0}}, 1'b1};
  assign sumIm  = {aIm[W-1], aIm} + {bIm[W-1], bIm} + {{W{1'b0}}, 1'b1};
  assign halfRe = sumRe >>> 1;
  assign halfIm = sumIm >>> 1;

  assign stsSampleRe = (cnt_q == 9'd0) ? (stsRe >>> 1) : stsRe;
  assign stsSampleIm = (cnt_q == 9'd0) ? (stsIm >>> 1) : stsIm;
  assign giSampleRe  = (cnt_q == 9'd0) ? halfRe[W-1:0] : ltsRe;
  assign giSampleIm  = (cnt_q == 9'd0) ? halfIm[W-1:0] : ltsIm;
`else
  assign stsSampleRe = stsRe;
  assign stsSampleIm = stsIm;
  assign giSampleRe  = ltsRe;
  assign giSampleIm  = ltsIm;
`endif

  // Next-state, counter and output-register load decisions for each section.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    outReal_d   = outReal_q;
    outImag_d   = outImag_q;
    outValid_d  = outValid_q;
    lastLts_d   = lastLts_q;
    lastBurst_d = lastBurst_q;
    din_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (advance) begin
          outValid_d  = 1'b0;
          lastLts_d   = 1'b0;
          lastBurst_d = 1'b0;
        end
        if (start) begin
          remaining_d = payload_len;
          busy_d      = 1'b1;
          cnt_d       = 9'd0;
          state_d     = STS;
        end
      end

      STS: begin
        if (advance) begin
          outReal_d   = stsSampleRe;
          outImag_d   = stsSampleIm;
          outValid_d  = 1'b1;
          lastLts_d   = 1'b0;
          lastBurst_d = 1'b0;
          if (cnt_q == STS_LAST) begin
            cnt_d   = 9'd0;
            state_d = (LTS_GI_LEN == 0) ? LTS_A : LTS_GI;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end

      LTS_GI: begin
        if (advance) begin
          outReal_d   = giSampleRe;
          outImag_d   = giSampleIm;
          outValid_d  = 1'b1;
          lastLts_d   = 1'b0;
          lastBurst_d = 1'b0;
          if (cnt_q == GI_LAST) begin
            cnt_d   = 9'd0;
            state_d = LTS_A;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end

      LTS_A: begin
        if (advance) begin
          outReal_d   = ltsRe;
          outImag_d   = ltsIm;
          outValid_d  = 1'b1;
          lastLts_d   = 1'b0;
          lastBurst_d = 1'b0;
          if (cnt_q == LTS_LAST) begin
            cnt_d   = 9'd0;
            state_d = LTS_B;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end

      LTS_B: begin
        if (advance) begin
          outReal_d   = ltsRe;
          outImag_d   = ltsIm;
          outValid_d  = 1'b1;
          lastLts_d   = 1'b0;
          lastBurst_d = 1'b0;
          if (cnt_q == LTS_LAST) begin
            cnt_d     = 9'd0;
            lastLts_d = 1'b1;
            if (remaining_q == '0) begin
              lastBurst_d = 1'b1;
              state_d     = FINISH;
            end else begin
              state_d = PAYLOAD;
            end
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end

      PAYLOAD: begin
        din_ready = advance && (remaining_q != '0);
        if (advance) begin
          lastLts_d   = 1'b0;
          lastBurst_d = 1'b0;
          if (din_valid && (remaining_q != '0)) begin
            outReal_d   = din_real;
            outImag_d   = din_imag;
            outValid_d  = 1'b1;
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              lastBurst_d = 1'b1;
              state_d     = FINISH;
            end
          end else begin
            outValid_d = 1'b0;
          end
        end
      end

      FINISH: begin
        if (accept && lastBurst_q) begin
          outValid_d  = 1'b0;
          lastLts_d   = 1'b0;
          lastBurst_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, sample counter, remaining payload and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
    end
  end

  // Output register with its end-of-preamble and end-of-burst tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outReal_q   <= '0;
      outImag_q   <= '0;
      outValid_q  <= 1'b0;
      lastLts_q   <= 1'b0;
      lastBurst_q <= 1'b0;
    end else begin
      outReal_q   <= outReal_d;
      outImag_q   <= outImag_d;
      outValid_q  <= outValid_d;
      lastLts_q   <= lastLts_d;
      lastBurst_q <= lastBurst_d;
    end
  end

  assign out_real      = outReal_q;
  assign out_imag      = outImag_q;
  assign out_valid     = outValid_q;
  assign busy          = busy_q;
  assign preamble_done = accept && lastLts_q;
  assign burst_done    = accept && lastBurst_q;

endmodule

// File: tb/tb_preamble_inserter.sv
// tb_preamble_inserter: directed bench for preamble_inserter at default
// parameters. Expected samples are queued when a burst is started and popped
// as the DUT hands samples downstream. Honours PREAMBLE_WINDOW_EN.

`ifndef FIXED_POINT_WIDTH
`define FIXED_POINT_WIDTH 13
`endif

module tb_preamble_inserter;

  localparam int W = `FIXED_POINT_WIDTH;
  localparam int PRE_LEN = 320;

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic                pre;
    logic                burst;
  } sample_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [11:0]   payload_len;
  logic [W-1:0]  din_real, din_imag;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  out_real, out_imag;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          preamble_done;
  logic          burst_done;

  int nCompared = 0;
  int nMismatched = 0;
  int accCount = 0;
  int preCount = 0;
  int burstCount = 0;
  sample_t sbQ[$];

  int stsRe [16] = '{47, -135, -13, 146, 94, 146, -13, -135, 47, 2, -81, -13, 0, -13, -81, 2};
  int stsIm [16] = '{47, 2, -81, -13, 0, -13, -81, 2, 47, -135, -13, 146, 94, 146, -13, -135};
  int ltsRe [64] = '{160, -5, 41, 99, 22, 61, -118, -39, 100, 54, 1, -140, 25, 60, -23, 122,
                     63, 38, -58, -134, 84, 72, -61, -57, -36, -125, -130, 77, -3, -94, 94, 12,
                     -160, 12, 94, -94, -3, 77, -130, -125, -36, -57, -61, 72, 84, -134, -58, 38,
                     63, 122, -23, 60, 25, -140, 1, 54, 100, -39, -118, 61, 22, 99, 41, -5};
  int ltsIm [64] = '{0, -123, -114, 85, 29, -90, -56, -109, -27, 4, -118, -48, -60, -15, 165, -4,
                     -63, 100, 40, 67, 94, 14, 83, -23, -155, -17, -22, -76, 55, 118, 109, 100,
                     0, -100, -109, -118, -55, 76, 22, 17, 155, 23, -83, -14, -94, -67, -40, -100,
                     63, 4, -165, 15, 60, 48, 118, -4, 27, 109, 56, 90, -29, -85, 114, 123};

  preamble_inserter dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .payload_len   (payload_len),
    .din_real      (din_real),
    .din_imag      (din_imag),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .out_real      (out_real),
    .out_imag      (out_imag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .preamble_done (preamble_done),
    .burst_done    (burst_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference preamble: STS periods, LTS tail as guard, two LTS symbols.
  function automatic sample_t preambleSample(input int k);
    sample_t s;
    int re, im;
    if (k < 160) begin
      re = stsRe[k % 16];
      im = stsIm[k % 16];
    end else if (k < 192) begin
      re = ltsRe[k - 160 + 32];
      im = ltsIm[k - 160 + 32];
    end else if (k < 256) begin
      re = ltsRe[k - 192];
      im = ltsIm[k - 192];
    end else begin
      re = ltsRe[k - 256];
      im = ltsIm[k - 256];
    end
`ifdef PREAMBLE_WINDOW_EN
    if (k == 0) begin
      re = re >>> 1;
      im = im >>> 1;
    end
    if (k == 160) begin
      re = (stsRe[15] + ltsRe[32] + 1) >>> 1;
      im = (stsIm[15] + ltsIm[32] + 1) >>> 1;
    end
`endif
    s.re = W'(re);
    s.im = W'(im);
    s.pre = 1'b0;
    s.burst = 1'b0;
    return s;
  endfunction

  task automatic pushBurst(input int len);
    sample_t s;
    for (int k = 0; k < PRE_LEN; k++) begin
      s = preambleSample(k);
      s.pre = (k == PRE_LEN - 1);
      s.burst = (k == PRE_LEN - 1) && (len == 0);
      sbQ.push_back(s);
    end
    for (int n = 1; n <= len; n++) begin
      s.re = W'(n);
      s.im = W'(n);
      s.pre = 1'b0;
      s.burst = (n == len);
      sbQ.push_back(s);
    end
  endtask

  // Scoreboard: every accepted output sample is checked against the queue head.
  always @(negedge clk) begin
    sample_t e;
    if (preamble_done === 1'b1) preCount++;
    if (burst_done === 1'b1) burstCount++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput($sformatf("unexpected sample %0d", accCount), 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput($sformatf("sample %0d real", accCount), $signed(out_real), e.re);
        checkOutput($sformatf("sample %0d imag", accCount), $signed(out_imag), e.im);
        checkOutput($sformatf("sample %0d preamble_done", accCount), preamble_done, e.pre);
        checkOutput($sformatf("sample %0d burst_done", accCount), burst_done, e.burst);
      end
      accCount++;
    end
  end

  // Starts a burst and checks the two-cycle start-to-first-sample latency.
  task automatic applyStimulus(input int len);
    sample_t first;
    first = preambleSample(0);
    pushBurst(len);
    accCount = 0;
    preCount = 0;
    burstCount = 0;
    @(posedge clk); #1;
    start = 1'b1;
    payload_len = 12'(len);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("latency t+1 out_valid", out_valid, 0);
    checkOutput("busy after start", busy, 1);
    @(negedge clk);
    checkOutput("latency t+2 out_valid", out_valid, 1);
    checkOutput("first sample real", $signed(out_real), first.re);
    checkOutput("first sample imag", $signed(out_imag), first.im);
    @(posedge clk); #1;
  endtask

  task automatic waitIdle(input bit toggle);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = toggle ? pat[c % 4] : 1'b1;
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    checkOutput("busy fell before timeout", done, 1);
  endtask

  task automatic feedPayload(input int n, input int pulseAt);
    bit got;
    for (int i = 1; i <= n; i++) begin
      din_real = W'(i);
      din_imag = W'(i);
      din_valid = 1'b1;
      start = (i == pulseAt);
      got = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (din_ready === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        checkOutput($sformatf("din_ready timeout at payload %0d", i), 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("din_ready low after last payload", din_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic endChecks(input int expAcc);
    checkOutput("scoreboard empty", sbQ.size(), 0);
    checkOutput("accepted sample count", accCount, expAcc);
    checkOutput("preamble_done pulses", preCount, 1);
    checkOutput("burst_done pulses", burstCount, 1);
    checkOutput("busy idle", busy, 0);
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    start = 1'b0;
    payload_len = '0;
    din_real = '0;
    din_imag = '0;
    din_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_real", $signed(out_real), 0);
    checkOutput("reset out_imag", $signed(out_imag), 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset din_ready", din_ready, 0);
    checkOutput("reset preamble_done", preamble_done, 0);
    checkOutput("reset burst_done", burst_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] preamble only, out_ready high");
    applyStimulus(0);
    waitIdle(1'b0);
    endChecks(PRE_LEN);

    $display("[TB] five payload samples");
    applyStimulus(5);
    feedPayload(5, 0);
    waitIdle(1'b0);
    endChecks(PRE_LEN + 5);

    $display("[TB] preamble with out_ready toggling");
    applyStimulus(0);
    waitIdle(1'b1);
    endChecks(PRE_LEN);

    $display("[TB] reset in mid-burst");
    applyStimulus(0);
    hit = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (accCount >= 100) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("reached sample 100", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-reset out_valid", out_valid, 0);
    checkOutput("mid-reset out_real", $signed(out_real), 0);
    checkOutput("mid-reset out_imag", $signed(out_imag), 0);
    checkOutput("mid-reset busy", busy, 0);
    sbQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0);
    waitIdle(1'b0);
    endChecks(PRE_LEN);

    $display("[TB] start pulsed during payload");
    applyStimulus(5);
    feedPayload(5, 3);
    waitIdle(1'b0);
    endChecks(PRE_LEN + 5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("no second burst busy", busy, 0);
    checkOutput("no second burst out_valid", out_valid, 0);
    checkOutput("no second burst queue", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/preamble_inserter.md
Name: preamble_inserter

Overview:
- Transmit-side framer that emits the OFDM training preamble ahead of each payload burst: a short training sequence (16-sample period, repeated), then the long training sequence (guard interval plus two 64-sample symbols).
- After the preamble it passes payload time-domain samples through until the burst ends.
- Sits between the IFFT/CP-insertion chain and the DAC/channel model. Its short-training section is what the receive-side coarse autocorrelator (lag 16, 15-sample window) locks onto.
- Samples are signed `FIXED_POINT_WIDTH (13) bits, Q2.10.

Parameters:
- STS_REPS, 10, number of 16-sample short-training repetitions (1..15).
- LTS_GI_LEN, 32, long-training guard length; taken as the last LTS_GI_LEN entries of the 64-entry LTS table (0..64).
- LEN_W, 12, width of the payload length input.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- payload_len  in  LEN_W  number of payload samples; latched on accepted start
- din_real  in  `FIXED_POINT_WIDTH  payload sample, real part
- din_imag  in  `FIXED_POINT_WIDTH  payload sample, imaginary part
- din_valid  in  1  payload sample available
- din_ready  out  1  payload sample accepted this cycle when din_valid is also high
- out_real  out  `FIXED_POINT_WIDTH  output sample, real part
- out_imag  out  `FIXED_POINT_WIDTH  output sample, imaginary part
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- busy  out  1  high from accepted start until the last sample is accepted
- preamble_done  out  1  one-cycle pulse when the last LTS sample is accepted
- burst_done  out  1  one-cycle pulse when the last sample of the burst is accepted

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Output register rule:
  - The output register loads when (!out_valid || out_ready).
  - While out_valid && !out_ready, out_real, out_imag and out_valid hold.
  - Nothing advances while the output is stalled.
- ROMs (constant tables in preamble_rom.vh, Q2.10):
  - STS: 16 entries; STS[0] = (47,47).
  - LTS: 64 entries; LTS[0] = (160,0).
- State IDLE:
  - start=1 -> latch payload_len, busy<=1, go to STS.
  - start is ignored in every other state.
- State STS:
  - Emits STS[k mod 16] for k = 0 .. 16*STS_REPS-1.
  - Next state: LTS_GI, or LTS_A if LTS_GI_LEN=0.
- State LTS_GI:
  - Emits LTS[64-LTS_GI_LEN+j] for j = 0 .. LTS_GI_LEN-1.
- States LTS_A, LTS_B:
  - Each emits LTS[0..63].
  - The last LTS_B sample, when accepted, pulses preamble_done.
  - Next state: PAYLOAD, or FINISH if payload_len=0.
- State PAYLOAD:
  - din_ready = (!out_valid || out_ready) && (remaining > 0), registered-path free (combinational from state/counter).
  - Accepted din is copied to the output register with 1-cycle latency.
  - remaining decrements per accepted sample.
  - A cycle with din_valid=0 loads out_valid=0; this is a bubble, not an error.
- State FINISH:
  - Waits until the last sample is accepted, then pulses burst_done, busy<=0, returns to IDLE.
- Latency: start at cycle t -> first STS sample has out_valid=1 at cycle t+2, assuming out_ready=1.
- Preamble sample count: 16*STS_REPS + LTS_GI_LEN + 128 = 320 at defaults. Preamble samples are contiguous, with no bubbles, when out_ready=1.
- Sample counter: 9 bits, wraps only via explicit reload at each state change.
- Simultaneous start with burst_done: start is ignored, since the block is not yet in IDLE; a new burst needs start after busy falls.
- Reset mid-burst: immediate return to IDLE with all outputs 0; the partial burst is dropped.

Optional Feature:
- Macro: PREAMBLE_WINDOW_EN.
- When defined:
  - The first STS sample of the burst is output at half amplitude (arithmetic shift right by 1, per component).
  - The first LTS_GI sample is output as the rounded average of the last STS sample and LTS[64-LTS_GI_LEN]: (a+b+1)>>>1 per component, computed in 14 bits and truncated to 13.
- When not defined: all samples are the raw ROM values. The sample count is the same in both modes.

Test Plan:
- Defaults, out_ready=1, start, payload_len=0:
  - Required: exactly 320 valid samples.
  - Samples 0, 16 and 144 are (47,47); sample 160 = LTS[32]; sample 192 = (160,0); sample 256 = (160,0).
  - preamble_done and burst_done both pulse on the cycle sample 319 is accepted.
- payload_len=5, din values 1..5 (real=imag=n), din_valid=1:
  - Required: samples 320..324 = (1,1)..(5,5).
  - din_ready is low after the 5th sample; burst_done pulses once.
- out_ready toggled 1,0,0,1 repeatedly:
  - Required: sample sequence identical to the first test.
  - Output is held while stalled; no sample is duplicated or lost.
- Assert rst at sample 100:
  - Required: outputs 0 and busy=0 next cycle.
  - A following start produces STS[0]=(47,47) first.
- start pulsed during PAYLOAD:
  - Required: ignored; one burst only, and busy falls after burst_done.
- With PREAMBLE_WINDOW_EN: sample 0 = (23,23); sample 160 = avg(STS[15], LTS[32]); all other samples as in the first test.
